midi_encoder: RTL and testbench

Serializes one decoded channel-voice MIDI message into the raw MIDI byte stream: a status byte followed by one or two data bytes. It is the transmit-side counterpart of `MIDIDecoder` and sits between message producers (parameter echo, sequencer) and the byte-level UART transmitter. It performs optional running-status compression with a periodic status refresh.

---
 rtl/midi_encoder_if.sv | 21 ++
 rtl/midi_encoder.sv | 94 +++++++++
 tb/tb_midi_encoder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/midi_encoder_if.sv
// midi_encoder_if: message-in / byte-out handshake bundle for the MIDI encoder.
interface midi_encoder_if;
    logic [3:0] msg_status;
    logic [3:0] msg_channel;
    logic [6:0] msg_data1;
    logic [6:0] msg_data2;
    logic       msg_valid;
    logic       msg_ready;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       msg_error;
    modport master (
        output msg_status, msg_channel, msg_data1, msg_data2, msg_valid, data_out_ready,
        input  msg_ready, data_out, data_out_valid, msg_error
    );
    modport slave (
        input  msg_status, msg_channel, msg_data1, msg_data2, msg_valid, data_out_ready,
        output msg_ready, data_out, data_out_valid, msg_error
    );
endinterface

// File: rtl/midi_encoder.sv
// midi_encoder: serializes one channel-voice MIDI message into status/data bytes,
// with optional running-status compression and a periodic status refresh.
module midi_encoder #(
    parameter bit RUNNING_STATUS = 1'b1,
    parameter int RS_REFRESH     = 16
) (
    input logic           clock_50_000_000,
    input logic           reset,
    midi_encoder_if.slave bus
);
    localparam int CW = $clog2(RS_REFRESH + 1);
    localparam logic [CW-1:0] RS_MAX = CW'(RS_REFRESH);
    typedef enum logic [1:0] {IDLE, STATUS, DATA1, DATA2} state_t;
    state_t        state_q, state_d;
    logic [3:0]    status_q, status_d, channel_q, channel_d;
    logic [6:0]    data1_q, data1_d, data2_q, data2_d;
    logic          sent_q, sent_d;
    logic [7:0]    last_status_q, last_status_d;
    logic          rs_valid_q, rs_valid_d;
    logic [CW-1:0] rs_count_q, rs_count_d;
    logic          error_q, error_d;
    logic          xfer, two_byte, last_byte, bad, omit;
    assign bus.msg_ready      = state_q == IDLE;
    assign bus.data_out_valid = state_q != IDLE;
    assign bus.msg_error      = error_q;
    assign bus.data_out       = state_q == STATUS ? {status_q, channel_q} :
                                state_q == DATA1  ? {1'b0, data1_q} :
                                state_q == DATA2  ? {1'b0, data2_q} : 8'h00;
    assign xfer      = bus.data_out_valid && bus.data_out_ready;
    assign two_byte  = status_q == 4'hC || status_q == 4'hD;
    assign last_byte = xfer && (state_q == DATA2 || (state_q == DATA1 && two_byte));
    assign bad       = !bus.msg_status[3] || bus.msg_status == 4'hF;
    // Status may be skipped only while the refresh budget is not yet exhausted
    assign omit      = RUNNING_STATUS && rs_valid_q && rs_count_q < RS_MAX &&
                       {bus.msg_status, bus.msg_channel} == last_status_q;
    always_comb begin
        state_d       = state_q;
        status_d      = status_q;
        channel_d     = channel_q;
        data1_d       = data1_q;
        data2_d       = data2_q;
        sent_d        = sent_q;
        last_status_d = last_status_q;
        rs_valid_d    = rs_valid_q;
        rs_count_d    = rs_count_q;
        error_d       = 1'b0;
        case (state_q)
            IDLE: if (bus.msg_valid) begin
                status_d  = bus.msg_status;
                channel_d = bus.msg_channel;
                data1_d   = bus.msg_data1;
                data2_d   = bus.msg_data2;
                error_d   = bad;
                sent_d    = !omit;
                state_d   = bad ? IDLE : omit ? DATA1 : STATUS;
            end
            STATUS:  state_d = xfer ? DATA1 : STATUS;
            DATA1:   state_d = xfer ? (two_byte ? IDLE : DATA2) : DATA1;
            default: state_d = xfer ? IDLE : DATA2;
        endcase
        if (last_byte && sent_q) begin
            last_status_d = {status_q, channel_q};
            rs_valid_d    = 1'b1;
            rs_count_d    = '0;
        end else if (last_byte) begin
            rs_count_d = rs_count_q == RS_MAX ? rs_count_q : rs_count_q + 1'b1;
        end
    end
    always_ff @(posedge clock_50_000_000 or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            status_q      <= '0;
            channel_q     <= '0;
            data1_q       <= '0;
            data2_q       <= '0;
            sent_q        <= 1'b0;
            last_status_q <= '0;
            rs_valid_q    <= 1'b0;
            rs_count_q    <= '0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            status_q      <= status_d;
            channel_q     <= channel_d;
            data1_q       <= data1_d;
            data2_q       <= data2_d;
            sent_q        <= sent_d;
            last_status_q <= last_status_d;
            rs_valid_q    <= rs_valid_d;
            rs_count_q    <= rs_count_d;
            error_q       <= error_d;
        end
    end
endmodule

// File: tb/tb_midi_encoder.sv
// tb_midi_encoder: three encoder configurations driven by the same message list,
// each checked against a message-level running-status model.
module tb_midi_encoder;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int n_chk = 0;
    int n_pass = 0;
    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask
    // kind: 0 random ready, 1 ready high + timing check, 2 long stall, 3 reset before last byte
    typedef struct packed {
        logic [3:0] st;
        logic [3:0] ch;
        logic [6:0] d1;
        logic [6:0] d2;
        logic [1:0] kind;
    } msg_t;
    msg_t stim[$];
    function automatic void add(input logic [3:0] st, ch, input logic [6:0] d1, d2, input logic [1:0] kind);
        stim.push_back({st, ch, d1, d2, kind});
    endfunction
    initial begin
        int r;
        add(4'h9, 4'h0, 7'h0A, 7'h50, 2'd1);
        add(4'h9, 4'h0, 7'h0A, 7'h50, 2'd1);
        repeat (4) add(4'hB, 4'h3, 7'h14, 7'd20, 2'd1);
        add(4'hC, 4'h1, 7'h05, 7'h33, 2'd1);
        add(4'hD, 4'h1, 7'h7F, 7'h7F, 2'd1);
        add(4'h8, 4'h0, 7'h1E, 7'h00, 2'd1);
        add(4'h8, 4'h0, 7'h1E, 7'h00, 2'd2);
        add(4'hF, 4'h0, 7'h12, 7'h34, 2'd1);
        add(4'h9, 4'h0, 7'h0A, 7'h50, 2'd3);
        add(4'h9, 4'h0, 7'h0A, 7'h50, 2'd1);
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            add(r < 7 ? 4'(8 + r) : r == 7 ? 4'hF : 4'(r - 5), 4'($urandom_range(0, 1)),
                7'($urandom), 7'($urandom),
                $urandom_range(0, 19) == 0 ? 2'd3 : $urandom_range(0, 4) == 0 ? 2'd1 : 2'd0);
        end
    end
    for (genvar g = 0; g < 3; g++) begin : u
        localparam bit RS = (g != 1);
        localparam int RF = (g == 2) ? 2 : 16;
        midi_encoder_if bus ();
        logic rst = 1'b1;
        logic [7:0] q[$];
        int rdy_mode = 0;
        bit done = 1'b0;
        bit stalled = 1'b0;
        logic [7:0] held;
        midi_encoder #(.RUNNING_STATUS(RS), .RS_REFRESH(RF)) dut (
            .clock_50_000_000(clk),
            .reset(rst),
            .bus(bus)
        );
        initial begin
            bus.data_out_ready = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                bus.data_out_ready = rdy_mode == 1 ? 1'b1 : rdy_mode == 2 ? 1'b0 : 1'($urandom_range(0, 3) != 0);
            end
        end
        always @(negedge clk) begin
            if (rst) stalled = 1'b0;
            else begin
                if (stalled) begin
                    chk($sformatf("%0d:hold_valid", g), bus.data_out_valid, 1);
                    chk($sformatf("%0d:hold_data", g), bus.data_out, held);
                end
                if (bus.msg_error) chk($sformatf("%0d:err_excl", g), bus.data_out_valid, 0);
                if (bus.data_out_valid && bus.data_out_ready) begin
                    if (q.size() == 0) chk($sformatf("%0d:unexpected_byte", g), q.size(), 1);
                    else chk($sformatf("%0d:byte", g), bus.data_out, q.pop_front());
                end
                stalled = bus.data_out_valid && !bus.data_out_ready;
                held = bus.data_out;
            end
        end
        initial begin
            msg_t m;
            logic [7:0] m_last;
            bit m_rsv, bad, omit;
            int m_cnt, nb, w, c;
            m_last = 8'h00;
            m_rsv = 1'b0;
            m_cnt = 0;
            bus.msg_valid = 1'b0;
            bus.msg_status = 4'h0;
            bus.msg_channel = 4'h0;
            bus.msg_data1 = 7'h0;
            bus.msg_data2 = 7'h0;
            repeat (3) @(negedge clk);
            chk($sformatf("%0d:rst_ready", g), bus.msg_ready, 1);
            chk($sformatf("%0d:rst_valid", g), bus.data_out_valid, 0);
            chk($sformatf("%0d:rst_data", g), bus.data_out, 0);
            chk($sformatf("%0d:rst_err", g), bus.msg_error, 0);
            rst = 1'b0;
            for (int i = 0; i < stim.size(); i++) begin
                m = stim[i];
                @(negedge clk);
                rdy_mode = m.kind == 2'd2 ? 2 : m.kind == 2'd0 ? 0 : 1;
                bus.msg_status = m.st;
                bus.msg_channel = m.ch;
                bus.msg_data1 = m.d1;
                bus.msg_data2 = m.d2;
                bus.msg_valid = 1'b1;
                w = 0;
                while (!bus.msg_ready && w < 200) begin
                    @(negedge clk);
                    w++;
                end
                if (!bus.msg_ready) chk($sformatf("%0d:accept_wait", g), bus.msg_ready, 1);
                @(posedge clk);
                #1;
                bus.msg_valid = 1'b0;
                bus.msg_status = 4'($urandom);
                bus.msg_channel = 4'($urandom);
                bus.msg_data1 = 7'($urandom);
                bus.msg_data2 = 7'($urandom);
                bad = !m.st[3] || m.st == 4'hF;
                omit = RS && m_rsv && {m.st, m.ch} == m_last && m_cnt < RF;
                nb = 0;
                if (!bad) begin
                    if (!omit) begin
                        q.push_back({m.st, m.ch});
                        m_last = {m.st, m.ch};
                        m_rsv = 1'b1;
                        m_cnt = 0;
                        nb++;
                    end else if (m_cnt < RF) m_cnt++;
                    q.push_back({1'b0, m.d1});
                    nb++;
                    if (m.st != 4'hC && m.st != 4'hD) begin
                        q.push_back({1'b0, m.d2});
                        nb++;
                    end
                end
                if (m.kind == 2'd3 && nb > 0) begin
                    repeat (nb - 1) @(posedge clk);
                    #1;
                    chk($sformatf("%0d:valid_pre_reset", g), bus.data_out_valid, 1);
                    rst = 1'b1;
                    #1;
                    chk($sformatf("%0d:arst_ready", g), bus.msg_ready, 1);
                    chk($sformatf("%0d:arst_valid", g), bus.data_out_valid, 0);
                    chk($sformatf("%0d:arst_data", g), bus.data_out, 0);
                    q.delete();
                    m_last = 8'h00;
                    m_rsv = 1'b0;
                    m_cnt = 0;
                    repeat (2) @(negedge clk);
                    rst = 1'b0;
                end else begin
                    @(negedge clk);
                    chk($sformatf("%0d:err_pulse", g), bus.msg_error, bad);
                    if (bad) begin
                        @(negedge clk);
                        chk($sformatf("%0d:err_one_cycle", g), bus.msg_error, 0);
                    end else begin
                        chk($sformatf("%0d:first_valid", g), bus.data_out_valid, 1);
                        if (m.kind == 2'd1) begin
                            c = 1;
                            while (!bus.msg_ready && c < 30) begin
                                @(negedge clk);
                                c++;
                            end
                            chk($sformatf("%0d:ready_return", g), c, nb + 1);
                        end
                        if (m.kind == 2'd2) begin
                            repeat (12) @(negedge clk);
                            rdy_mode = 1;
                        end
                    end
                end
            end
            w = 0;
            while (q.size() != 0 && w < 200) begin
                @(negedge clk);
                w++;
            end
            chk($sformatf("%0d:drain", g), q.size(), 0);
            done = 1'b1;
        end
    end
    initial begin
        for (int t = 0; t < 60000 && !(u[0].done && u[1].done && u[2].done); t++) @(negedge clk);
        chk("all_done", u[0].done && u[1].done && u[2].done, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
